// File: rtl/parity_pkg.sv
// Shared parity definitions: PAR_TYP encodings and the RX parity checker FSM states.
package parity_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_typ_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ACCUM    = 2'b01,
        PAR_WAIT = 2'b10,
        REPORT   = 2'b11
    } par_state_e;

endpackage

// File: rtl/par_gen.sv
// Expected parity bit for a data word under a given PAR_TYP; shared by the RX checker and TX generator.
module par_gen
    import parity_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  par_typ_e          par_typ,
    output logic              exp_bit
);

    always_comb begin
        exp_bit = 1'b0;
        case (par_typ)
            PAR_EVEN:  exp_bit = ^data;
            PAR_ODD:   exp_bit = ~(^data);
            PAR_MARK:  exp_bit = 1'b1;
            PAR_SPACE: exp_bit = 1'b0;
            default:   exp_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/parity_check_gen.sv
// RX parity checker: accumulates a serial data frame, checks the parity bit and
// reports the captured word with parity and sequencing error flags.
module parity_check_gen
    import parity_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              frame_start,
    input  logic              data_bit_en,
    input  logic              par_chk_en,
    input  logic              sampled_bit,
    input  logic              PAR_EN,
    input  logic [1:0]        PAR_TYP,
    output logic [DATA_W-1:0] P_DATA,
    output logic              par_valid,
    output logic              par_err,
    output logic              cnt_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);

    par_state_e        state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic              par_acc, acc_nxt;
    logic [DATA_W-1:0] data_sr, data_nxt;
    logic              par_en_q, pen_nxt;
    par_typ_e          par_typ_q, typ_nxt;
    logic              pend_err, pend_nxt;
    logic [DATA_W-1:0] pdata_nxt;
    logic              perr_nxt, cerr_nxt, report;
    logic              exp_bit;

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d, input logic b);
        if (LSB_FIRST != 0)
            return {b, d[DATA_W-1:1]};
        else
            return {d[DATA_W-2:0], b};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // The running parity is the XOR of the word so far, so a 1-bit instance yields the expected bit.
    par_gen #(.DATA_W(1)) u_par_gen (
        .data    (par_acc),
        .par_typ (par_typ_q),
        .exp_bit (exp_bit)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        acc_nxt   = par_acc;
        data_nxt  = data_sr;
        pen_nxt   = par_en_q;
        typ_nxt   = par_typ_q;
        pend_nxt  = pend_err;
        pdata_nxt = P_DATA;
        perr_nxt  = par_err;
        cerr_nxt  = cnt_err;
        report    = 1'b0;

        if (frame_start) begin
            // A restart always wins; a coincident data bit becomes bit 0 of the new frame.
            state_nxt = ACCUM;
            cnt_nxt   = '0;
            acc_nxt   = 1'b0;
            data_nxt  = '0;
            pend_nxt  = 1'b0;
            pen_nxt   = PAR_EN;
            typ_nxt   = par_typ_e'(PAR_TYP);
            if (data_bit_en) begin
                data_nxt = shift_in('0, sampled_bit);
                acc_nxt  = sampled_bit;
                cnt_nxt  = CNT_W'(1);
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (par_chk_en) begin
                        report    = 1'b1;
                        pdata_nxt = data_sr;
                        perr_nxt  = 1'b1;
                        cerr_nxt  = 1'b1;
                    end else if (data_bit_en) begin
                        data_nxt = shift_in(data_sr, sampled_bit);
                        acc_nxt  = par_acc ^ sampled_bit;
                        cnt_nxt  = sat_inc(bit_cnt);
                        if (bit_cnt == CNT_LAST) begin
                            if (par_en_q) begin
                                state_nxt = PAR_WAIT;
                            end else begin
                                report    = 1'b1;
                                pdata_nxt = shift_in(data_sr, sampled_bit);
                                perr_nxt  = 1'b0;
                                cerr_nxt  = 1'b0;
                            end
                        end
                    end
                end
                PAR_WAIT: begin
                    if (par_chk_en) begin
                        report    = 1'b1;
                        pdata_nxt = data_sr;
                        if (data_bit_en) begin
                            perr_nxt = 1'b1;
                            cerr_nxt = 1'b1;
                        end else begin
                            perr_nxt = sampled_bit ^ exp_bit;
                            cerr_nxt = pend_err;
                        end
                    end else if (data_bit_en) begin
                        pend_nxt = 1'b1;
                    end
                end
                REPORT:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
            if (report) state_nxt = REPORT;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            par_acc   <= 1'b0;
            data_sr   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            pend_err  <= 1'b0;
            P_DATA    <= '0;
            par_valid <= 1'b0;
            par_err   <= 1'b0;
            cnt_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= cnt_nxt;
            par_acc   <= acc_nxt;
            data_sr   <= data_nxt;
            par_en_q  <= pen_nxt;
            par_typ_q <= typ_nxt;
            pend_err  <= pend_nxt;
            P_DATA    <= pdata_nxt;
            par_valid <= report;
            par_err   <= perr_nxt;
            cnt_err   <= cerr_nxt;
        end
    end

endmodule

// File: doc/parity_check_gen.md
PARITY_CHECK_GEN -- requirements
Module: parity_check_gen

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame, legal range 5..9.
REQ-002 Parameter LSB_FIRST, default 1, 1 = first data bit is bit 0 of P_DATA, 0 = first data bit is MSB.
REQ-003 CLK  input  1  single clock for all state, rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 frame_start  input  1  one-cycle pulse, clears the accumulator and begins a new frame.
REQ-006 data_bit_en  input  1  qualifies sampled_bit as the next data bit.
REQ-007 par_chk_en  input  1  qualifies sampled_bit as the received parity bit.
REQ-008 sampled_bit  input  1  serial bit from the RX sampler.
REQ-009 PAR_EN  input  1  1 = frame carries a parity bit, 0 = no parity bit.
REQ-010 PAR_TYP  input  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
REQ-011 P_DATA  output  DATA_W  captured data word, valid when par_valid = 1.
REQ-012 par_valid  output  1  one-cycle strobe, frame check complete.
REQ-013 par_err  output  1  parity mismatch, qualified by par_valid.
REQ-014 cnt_err  output  1  sequencing error, qualified by par_valid.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, PAR_WAIT and REPORT.
REQ-016 IDLE -> ACCUM on frame_start.
REQ-017 ACCUM, on data_bit_en: store the bit, XOR it into a running parity register, increment bit_cnt.
REQ-018 ACCUM -> PAR_WAIT when bit_cnt reaches DATA_W and PAR_EN = 1.
REQ-019 ACCUM -> REPORT when bit_cnt reaches DATA_W and PAR_EN = 0; par_err = 0 in this case.
REQ-020 PAR_WAIT -> REPORT on par_chk_en.
REQ-021 Expected parity bit: even = XOR of the data bits; odd = inverse of that XOR; mark = 1; space = 0.
REQ-022 par_err = sampled_bit XOR expected bit, registered on the par_chk_en cycle.
REQ-023 REPORT lasts exactly one cycle: par_valid = 1, then -> IDLE.
REQ-024 Latency: par_valid SHALL rise one cycle after the qualifying par_chk_en, or one cycle after the final data_bit_en when PAR_EN = 0.
REQ-025 P_DATA, par_err and cnt_err SHALL hold their values until the next REPORT.
REQ-026 par_chk_en received in ACCUM (early parity bit) -> REPORT, cnt_err = 1, par_err = 1.
REQ-027 data_bit_en and par_chk_en asserted together -> REPORT, cnt_err = 1, par_err = 1.
REQ-028 data_bit_en received in PAR_WAIT is ignored; cnt_err = 1 is reported at the next REPORT.
REQ-029 par_chk_en, or data_bit_en, received in IDLE or REPORT is ignored.
REQ-030 frame_start in any state restarts the frame (clears the accumulator and bit_cnt, -> ACCUM); an aborted frame produces no par_valid.
REQ-031 frame_start and data_bit_en asserted together: the bit is accumulated as data bit 0 of the new frame.
REQ-032 PAR_EN and PAR_TYP SHALL be sampled at frame_start and held for the whole frame.
REQ-033 The bit counter SHALL be ceil(log2(DATA_W+1)) bits wide and SHALL saturate without wrapping.

Reset
REQ-034 RST = 1 SHALL force IDLE asynchronously and clear bit_cnt, the parity register, P_DATA, par_valid, par_err and cnt_err to 0.
REQ-035 Reset during a frame SHALL discard that frame; no par_valid is produced.
REQ-036 After reset deasserts, the block SHALL ignore all inputs until frame_start.

Structure
REQ-037 Shared package parity_pkg SHALL hold the PAR_TYP encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE) and the FSM state encoding.
REQ-038 The expected-bit computation SHALL be a sub-module par_gen (data word + PAR_TYP -> expected bit), shared with the TX parity calculator.
REQ-039 All state SHALL be in a single clocked process; no latches SHALL be inferred.

Verification
REQ-040 DATA_W=8, LSB_FIRST=1, even, data 0xA5, parity bit 0 -> par_valid one cycle later, P_DATA=0xA5, par_err=0, cnt_err=0.
REQ-041 Odd mode, data 0xA5, parity bit 0 -> par_err=1; repeat with parity bit 1 -> par_err=0.
REQ-042 Mark mode, parity bit 0 -> par_err=1; space mode, parity bit 0 -> par_err=0; PAR_EN=0 with 8 bits of 0x3C -> par_valid after the last bit, par_err=0.
REQ-043 par_chk_en after only 5 data bits -> par_valid, cnt_err=1, par_err=1; an extra data_bit_en in PAR_WAIT -> cnt_err=1 at the next REPORT.
REQ-044 RST asserted after 4 data bits -> outputs 0 immediately, no par_valid; a clean frame afterwards passes with par_err=0.
REQ-045 DATA_W=9, LSB_FIRST=0, even, data 0x1FF, parity bit 1 -> P_DATA=0x1FF, par_err=0; frame_start mid-frame -> the old frame is dropped and the new one passes.
